// File: rtl/tcm_port_arbiter.sv
// Arbitrates the single TCM read/write port between the core load/store path and the debug loader.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; fixed core priority otherwise.
module tcm_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4095
) (
  input  logic              clk,
  input  logic              cpu_rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SHARED, LOCKED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

  localparam logic [11:0] LOCK_LAST = (LOCK_MAX == 0) ? 12'd0 : 12'(LOCK_MAX - 1);

  state_t      state;
  owner_t      rd_owner;
  logic [11:0] lock_cnt;
  logic        rel_hold;
  logic        core_win;
  logic        dbg_win;
  logic        lock_at_max;
`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_last_dbg;
`endif

  assign lock_at_max = (LOCK_MAX != 0) && (lock_cnt == LOCK_LAST);

  // Grant stage: winner selection is combinational so core_gnt lands in the request cycle
  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (cpu_rst) begin
      if (state == LOCKED) begin
        dbg_win = dbg_req;
      end else if (core_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        core_win = rel_hold | rr_last_dbg;
`else
        core_win = 1'b1;
`endif
        dbg_win = ~core_win;
      end else begin
        core_win = core_req;
        dbg_win  = dbg_req;
      end
    end
  end

  assign core_gnt   = core_win;
  assign dbg_gnt    = dbg_win;
  assign core_stall = cpu_rst & core_req & ~core_win;
  assign mem_en     = core_win | dbg_win;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_win) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Response stage: read data returns one cycle after the grant, steered by rd_owner
  assign core_rvalid = (rd_owner == OWN_CORE);
  assign dbg_rvalid  = (rd_owner == OWN_DBG);
  assign core_rdata  = cpu_rst ? mem_rdata : '0;
  assign dbg_rdata   = cpu_rst ? mem_rdata : '0;

  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state    <= IDLE;
      rd_owner <= OWN_NONE;
      lock_cnt <= '0;
      rel_hold <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_dbg <= 1'b1;
`endif
    end else begin
      if (core_win && !core_we)     rd_owner <= OWN_CORE;
      else if (dbg_win && !dbg_we)  rd_owner <= OWN_DBG;
      else                          rd_owner <= OWN_NONE;

      rel_hold <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (state != LOCKED && core_req && dbg_req) rr_last_dbg <= dbg_win;
`endif

      case (state)
        IDLE, SHARED: begin
          // Just after a forced release the loader may not re-lock, giving the core one slot
          if (dbg_win && dbg_lock && !rel_hold) state <= LOCKED;
          else if (core_req || dbg_req)         state <= SHARED;
          else if (rd_owner == OWN_NONE)        state <= IDLE;
        end
        LOCKED: begin
          if (!dbg_lock || lock_at_max) begin
            state    <= SHARED;
            lock_cnt <= '0;
            rel_hold <= dbg_lock;
          end else if (lock_cnt != 12'hFFF) begin
            lock_cnt <= lock_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: two instances (LOCK_MAX 4095 and 8) share stimulus and are checked
// every cycle against a rule-level model, plus directed literal expectations.
module tb_tcm_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_rst;
  logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata;

  logic          core_gnt_o [2];
  logic          core_rvalid_o [2];
  logic          core_stall_o [2];
  logic          dbg_gnt_o [2];
  logic          dbg_rvalid_o [2];
  logic          mem_en_o [2];
  logic          mem_we_o [2];
  logic [AW-1:0] mem_addr_o [2];
  logic [DW-1:0] mem_wdata_o [2];
  logic [DW-1:0] core_rdata_o [2];
  logic [DW-1:0] dbg_rdata_o [2];
  logic [DW-1:0] mem_rdata_i [2];

  int checks = 0;
  int failures = 0;

  tcm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(4095)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_o[0]), .core_rvalid(core_rvalid_o[0]), .core_rdata(core_rdata_o[0]),
    .core_stall(core_stall_o[0]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt_o[0]), .dbg_rvalid(dbg_rvalid_o[0]),
    .dbg_rdata(dbg_rdata_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_i[0])
  );

  tcm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(8)) dut8 (
    .clk(clk), .cpu_rst(cpu_rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt_o[1]), .core_rvalid(core_rvalid_o[1]), .core_rdata(core_rdata_o[1]),
    .core_stall(core_stall_o[1]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt_o[1]), .dbg_rvalid(dbg_rvalid_o[1]),
    .dbg_rdata(dbg_rdata_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_i[1])
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a == 12'h004) ? 32'hDEADBEEF : (32'hC0DE0000 | {20'd0, a});
  endfunction

  // Memory responder per instance: 1-cycle read latency, zero when not reading
  logic [DW-1:0] rmem [8192];
  logic [8191:0] rmem_seen = '0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!cpu_rst) begin
        mem_rdata_i[k] <= '0;
      end else if (mem_en_o[k] && !mem_we_o[k]) begin
        mem_rdata_i[k] <= rmem_seen[k*4096 + int'(mem_addr_o[k])] ?
                          rmem[k*4096 + int'(mem_addr_o[k])] : init_word(mem_addr_o[k]);
      end else begin
        mem_rdata_i[k] <= '0;
      end
      if (cpu_rst && mem_en_o[k] && mem_we_o[k]) begin
        rmem[k*4096 + int'(mem_addr_o[k])]      <= mem_wdata_o[k];
        rmem_seen[k*4096 + int'(mem_addr_o[k])] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rule-level model state
  bit            m_locked [2];
  bit            m_hold [2];
  bit            m_rr_dbg [2];
  int            m_cnt [2];
  int            m_rd_owner [2];
  logic [DW-1:0] m_rd_data [2];
  logic [DW-1:0] ref_mem [8192];
  logic [8191:0] ref_seen = '0;
  int            lmax [2] = '{4095, 8};

  task automatic model_step(input int k);
    logic cg, dg, we, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    string p;
    p = (k == 0) ? "lm4095" : "lm8";
    if (!cpu_rst) begin
      chk({p, ".rst.core_gnt"}, 32'(core_gnt_o[k]), 0);
      chk({p, ".rst.dbg_gnt"}, 32'(dbg_gnt_o[k]), 0);
      chk({p, ".rst.core_stall"}, 32'(core_stall_o[k]), 0);
      chk({p, ".rst.mem_en"}, 32'(mem_en_o[k]), 0);
      chk({p, ".rst.core_rvalid"}, 32'(core_rvalid_o[k]), 0);
      chk({p, ".rst.dbg_rvalid"}, 32'(dbg_rvalid_o[k]), 0);
      chk({p, ".rst.core_rdata"}, core_rdata_o[k], 0);
      chk({p, ".rst.mem_addr"}, 32'(mem_addr_o[k]), 0);
      m_locked[k] = 0; m_hold[k] = 0; m_rr_dbg[k] = 1; m_cnt[k] = 0;
      m_rd_owner[k] = 0; m_rd_data[k] = '0;
      return;
    end
    cg = 0; dg = 0;
    if (m_locked[k]) begin
      dg = dbg_req;
    end else if (core_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      cg = m_hold[k] || m_rr_dbg[k];
`else
      cg = 1;
`endif
      dg = !cg;
      m_rr_dbg[k] = dg;
    end else begin
      cg = core_req;
      dg = dbg_req;
    end
    we = cg ? core_we : (dg ? dbg_we : 1'b0);
    a  = cg ? core_addr : (dg ? dbg_addr : '0);
    wd = cg ? core_wdata : (dg ? dbg_wdata : '0);

    chk({p, ".core_gnt"}, 32'(core_gnt_o[k]), 32'(cg));
    chk({p, ".dbg_gnt"}, 32'(dbg_gnt_o[k]), 32'(dg));
    chk({p, ".core_stall"}, 32'(core_stall_o[k]), 32'(core_req && !cg));
    chk({p, ".mem_en"}, 32'(mem_en_o[k]), 32'(cg || dg));
    chk({p, ".mem_we"}, 32'(mem_we_o[k]), 32'(we));
    chk({p, ".mem_addr"}, 32'(mem_addr_o[k]), 32'(a));
    chk({p, ".mem_wdata"}, mem_wdata_o[k], wd);
    chk({p, ".core_rvalid"}, 32'(core_rvalid_o[k]), 32'(m_rd_owner[k] == 1));
    chk({p, ".dbg_rvalid"}, 32'(dbg_rvalid_o[k]), 32'(m_rd_owner[k] == 2));
    chk({p, ".core_rdata"}, core_rdata_o[k], m_rd_data[k]);
    chk({p, ".dbg_rdata"}, dbg_rdata_o[k], m_rd_data[k]);

    rd = (cg || dg) && !we;
    m_rd_owner[k] = rd ? (cg ? 1 : 2) : 0;
    m_rd_data[k]  = rd ? (ref_seen[k*4096 + int'(a)] ? ref_mem[k*4096 + int'(a)] : init_word(a)) : '0;
    if ((cg || dg) && we) begin
      ref_mem[k*4096 + int'(a)]  = wd;
      ref_seen[k*4096 + int'(a)] = 1'b1;
    end

    if (m_locked[k]) begin
      m_cnt[k]++;
      if (!dbg_lock || (lmax[k] != 0 && m_cnt[k] == lmax[k])) begin
        m_locked[k] = 0;
        m_hold[k]   = dbg_lock;
        m_cnt[k]    = 0;
      end
    end else begin
      if (dg && dbg_lock && !m_hold[k]) m_locked[k] = 1;
      m_hold[k] = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic dl, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk); #1;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  logic [3:0] exp_cg;
  int stall_cnt, wr_cnt;

  initial begin
    cpu_rst = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1 cpu_rst = 1'b1;
    idle(); idle();

    // Reset mid-read drops the pending response
    drive(1, 0, 12'h010, '0, 0, 0, 0, '0, '0);
    sample();
    chk("t1_gnt_before_rst", 32'(core_gnt_o[0]), 1);
    cpu_rst = 1'b0;
    sample();
    chk("t1_rst_core_gnt", 32'(core_gnt_o[0]), 0);
    chk("t1_rst_core_stall", 32'(core_stall_o[0]), 0);
    chk("t1_rst_mem_en", 32'(mem_en_o[0]), 0);
    chk("t1_rst_core_rvalid", 32'(core_rvalid_o[0]), 0);
    @(posedge clk); #1;
    cpu_rst = 1'b1; core_req = 0;
    sample();
    chk("t1_post_rst_core_rvalid", 32'(core_rvalid_o[0]), 0);
    chk("t1_post_rst_dbg_rvalid", 32'(dbg_rvalid_o[0]), 0);

    // Core-only read
    drive(1, 0, 12'h004, '0, 0, 0, 0, '0, '0);
    sample();
    chk("t2_core_gnt", 32'(core_gnt_o[0]), 1);
    chk("t2_mem_addr", 32'(mem_addr_o[0]), 32'h004);
    chk("t2_mem_we", 32'(mem_we_o[0]), 0);
    idle();
    sample();
    chk("t2_core_rvalid", 32'(core_rvalid_o[0]), 1);
    chk("t2_core_rdata", core_rdata_o[0], 32'hDEADBEEF);
    chk("t2_dbg_rvalid", 32'(dbg_rvalid_o[0]), 0);

    // Contention for 4 cycles
`ifdef ARB_ROUND_ROBIN_EN
    exp_cg = 4'b0101;
`else
    exp_cg = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 12'h100 + 12'(i), 32'h1000 + 32'(i), 1, 1, 0, 12'h200 + 12'(i), 32'h2000 + 32'(i));
      sample();
      chk($sformatf("t3_core_gnt_%0d", i), 32'(core_gnt_o[0]), 32'(exp_cg[i]));
      chk($sformatf("t3_dbg_gnt_%0d", i), 32'(dbg_gnt_o[0]), 32'(!exp_cg[i]));
      chk($sformatf("t3_core_stall_%0d", i), 32'(core_stall_o[0]), 32'(!exp_cg[i]));
    end
    idle();

    // Loader lock: 16 writes, core stalled until release
    stall_cnt = 0; wr_cnt = 0;
    drive(0, 0, '0, '0, 1, 1, 1, 12'h000, 32'hA0);
    sample();
    chk("t4_lock_gnt", 32'(dbg_gnt_o[0]), 1);
    if (dbg_gnt_o[0] && mem_we_o[0] && mem_addr_o[0] == 12'h000) wr_cnt++;
    for (int i = 1; i < 16; i++) begin
      drive(1, 0, 12'h050, '0, 1, 1, 1, 12'(i), 32'hA0 + 32'(i));
      sample();
      if (core_stall_o[0]) stall_cnt++;
      if (dbg_gnt_o[0] && mem_we_o[0] && mem_addr_o[0] == 12'(i)) wr_cnt++;
    end
    drive(1, 0, 12'h050, '0, 0, 0, 0, '0, '0);
    sample();
    if (core_stall_o[0]) stall_cnt++;
    chk("t4_stall_cycles", 32'(stall_cnt), 16);
    chk("t4_dbg_writes", 32'(wr_cnt), 16);
    drive(1, 0, 12'h050, '0, 0, 0, 0, '0, '0);
    sample();
    chk("t4_core_gnt_after_unlock", 32'(core_gnt_o[0]), 1);
    idle(); idle();

    // Forced release on the LOCK_MAX=8 instance
    drive(0, 0, '0, '0, 1, 1, 1, 12'h300, 32'hB0);
    sample();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 12'h350, 32'hC5, 1, 1, 1, 12'h300 + 12'(i), 32'hB0 + 32'(i));
      sample();
      chk($sformatf("t5_locked_dbg_gnt_%0d", i), 32'(dbg_gnt_o[1]), 1);
      chk($sformatf("t5_locked_stall_%0d", i), 32'(core_stall_o[1]), 1);
    end
    drive(1, 1, 12'h350, 32'hC5, 1, 1, 1, 12'h309, 32'hB9);
    sample();
    chk("t5_release_core_gnt", 32'(core_gnt_o[1]), 1);
    chk("t5_release_dbg_gnt", 32'(dbg_gnt_o[1]), 0);
    drive(0, 0, '0, '0, 1, 1, 1, 12'h30A, 32'hBA);
    sample();
    chk("t5_relock_dbg_gnt", 32'(dbg_gnt_o[1]), 1);
    drive(1, 1, 12'h351, 32'hC6, 1, 1, 1, 12'h30B, 32'hBB);
    sample();
    chk("t5_relocked_core_gnt", 32'(core_gnt_o[1]), 0);
    chk("t5_relocked_stall", 32'(core_stall_o[1]), 1);
    idle(); idle(); idle();

    // Interleaved reads
    drive(1, 0, 12'h020, '0, 0, 0, 0, '0, '0);
    sample();
    chk("t6_core_gnt", 32'(core_gnt_o[0]), 1);
    drive(0, 0, '0, '0, 1, 0, 0, 12'h021, '0);
    sample();
    chk("t6_dbg_gnt", 32'(dbg_gnt_o[0]), 1);
    chk("t6_core_rvalid", 32'(core_rvalid_o[0]), 1);
    chk("t6_core_rdata", core_rdata_o[0], 32'hC0DE0020);
    idle();
    sample();
    chk("t6_dbg_rvalid", 32'(dbg_rvalid_o[0]), 1);
    chk("t6_dbg_rdata", dbg_rdata_o[0], 32'hC0DE0021);
    chk("t6_core_rvalid_clear", 32'(core_rvalid_o[0]), 0);
    idle();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
